// File: rtl/data_ram_responder_pkg.sv
// Shared RAM-port types for the data-memory interface, plus small address helpers
// used by the responder.
package data_ram_responder_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef logic        chip_status_t;
    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;
    typedef logic [3:0]  ram_sel_t;

    typedef struct packed {
        chip_status_t ce;
        logic         we;
        ram_sel_t     sel;
        ram_addr_t    addr;
        ram_data_t    data;
    } ram_req_t;

    typedef struct packed {
        logic      ack;
        logic      err;
        ram_data_t data;
    } ram_resp_t;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    function automatic logic addr_in_range(ram_addr_t addr, ram_addr_t base, int depth_words);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth_words) << 2);
        return (a >= lo) && (a < hi);
    endfunction

    function automatic ram_addr_t word_offset(ram_addr_t addr, ram_addr_t base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_bank.sv
// Single-port synchronous data store: DEPTH_WORDS x 32 with per-byte write
// enables and a registered read port.
module ram_bank
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  ram_sel_t      sel,
    input  logic [AW-1:0] idx,
    input  ram_data_t     wdata,
    output ram_data_t     rdata
);

    ram_data_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel[k]) begin
                        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// performs the access and returns a one-cycle ack with range error flag.
//
// state  | meaning
// IDLE   | waiting for ce_i; request inputs sampled only here
// WAIT   | request latched, wait-state counter running down to zero
// RESP   | access done on entry; ack_o (and err_o/data_o) valid this cycle
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int        DEPTH_WORDS = 1024,
    parameter int        WAIT_CYCLES = 1,
    parameter ram_addr_t BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  chip_status_t ce_i,
    input  logic         we_i,
    input  ram_sel_t     sel_i,
    input  ram_addr_t    addr_i,
    input  ram_data_t    data_i,
    output ram_data_t    data_o,
    output logic         ack_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;
    logic       busy_q;
    logic       err_q;
    ram_req_t   req_q;

    ram_req_t      req_in;
    ram_req_t      acc;
    logic          go_resp;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;
    logic          bank_en;
    ram_data_t     bank_rdata;
    ram_resp_t     resp;

    assign req_in = '{ce: ce_i, we: we_i, sel: sel_i, addr: addr_i, data: data_i};

    // With zero wait states the access happens on the accepting edge, so it
    // must use the live inputs rather than the latch.
    always_comb begin
        acc       = req_q;
        go_resp   = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                acc = req_in;
                if (ce_i == CHIP_ENABLE) begin
                    if (WAIT_CYCLES == 0) begin
                        go_resp   = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    go_resp   = (req_q.ce == CHIP_ENABLE);
                    state_nxt = S_RESP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign acc_in_range = addr_in_range(acc.addr, BASE_ADDR, DEPTH_WORDS);
    assign acc_idx      = AW'(word_offset(acc.addr, BASE_ADDR));
    assign bank_en      = go_resp && acc_in_range && (rst != RST_ENABLE);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            req_q  <= '0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != S_IDLE);
            if (state == S_IDLE && ce_i == CHIP_ENABLE) begin
                req_q <= req_in;
                cnt   <= WAIT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) begin
                err_q <= !acc_in_range;
            end
        end
    end

    ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (acc.we),
        .sel   (acc.sel),
        .idx   (acc_idx),
        .wdata (acc.data),
        .rdata (bank_rdata)
    );

    always_comb begin
        resp      = '0;
        resp.ack  = (state == S_RESP);
        resp.err  = resp.ack && err_q;
        resp.data = (resp.ack && !err_q && !req_q.we) ? bank_rdata : '0;
    end

    assign ack_o  = resp.ack;
    assign err_o  = resp.err;
    assign data_o = resp.data;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) driven with directed
// and random requests, checked against a word-array reference model.
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      ce_a, ce_b, we;
    ram_sel_t  sel;
    ram_addr_t addr;
    ram_data_t wdata;
    ram_data_t data_a, data_b;
    logic      ack_a, ack_b, err_a, err_b, busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [2][1024];
    bit          mdl_ok  [2][1024];

    always #5 clk = ~clk;

    data_ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we), .sel_i(sel), .addr_i(addr),
        .data_i(wdata), .data_o(data_a), .ack_o(ack_a), .err_o(err_a), .busy_o(busy_a)
    );

    data_ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(we), .sel_i(sel), .addr_i(addr),
        .data_i(wdata), .data_o(data_b), .ack_o(ack_b), .err_o(err_b), .busy_o(busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on unit u (0: 2 wait states, 1: none); checks latency, pulse width,
    // error flag and load data against the model, then updates the model.
    task automatic do_req(input int u, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        int   wc;
        int   n;
        bit   in_rng;
        int   idx;
        logic got_ack, got_err;
        logic [31:0] got_data, exp_word;
        wc = (u == 0) ? 2 : 0;
        @(negedge clk);
        we = w; sel = s; addr = a; wdata = d;
        if (u == 0) ce_a = 1'b1; else ce_b = 1'b1;
        @(negedge clk);
        ce_a = 1'b0; ce_b = 1'b0;
        n = 1;
        forever begin
            got_ack = (u == 0) ? ack_a : ack_b;
            if (got_ack || n >= wc + 5) break;
            @(negedge clk);
            n++;
        end
        got_err  = (u == 0) ? err_a : err_b;
        got_data = (u == 0) ? data_a : data_b;
        check_val($sformatf("latency u%0d", u), n, wc + 1);
        in_rng = ({1'b0, a} < 33'd4096);
        idx    = int'(a[11:2]);
        check_val($sformatf("err u%0d a=%h", u, a), {31'd0, got_err}, {31'd0, !in_rng});
        if (!in_rng) begin
            check_val($sformatf("err data u%0d", u), got_data, 32'h0);
        end else if (w) begin
            exp_word = mdl_mem[u][idx];
            for (int k = 0; k < 4; k++)
                if (s[k]) exp_word[8*k +: 8] = d[8*k +: 8];
            mdl_mem[u][idx] = exp_word;
            if (s == 4'hF) mdl_ok[u][idx] = 1'b1;
        end else if (mdl_ok[u][idx]) begin
            check_val($sformatf("load u%0d a=%h", u, a), got_data, mdl_mem[u][idx]);
        end
        @(negedge clk);
        got_ack = (u == 0) ? ack_a : ack_b;
        check_val($sformatf("ack width u%0d", u), {31'd0, got_ack}, 32'd0);
    endtask

    // ce held high: acks expected on every (wc+2)th cycle, first at wc+1.
    task automatic hold_test(input int u);
        int   wc;
        logic got_ack;
        wc = (u == 0) ? 2 : 0;
        @(negedge clk);
        we = 1'b0; sel = 4'h0; addr = 32'h10;
        if (u == 0) ce_a = 1'b1; else ce_b = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            got_ack = (u == 0) ? ack_a : ack_b;
            check_val($sformatf("hold u%0d n=%0d", u, n), {31'd0, got_ack},
                      {31'd0, (n % (wc + 2)) == (wc + 1)});
        end
        ce_a = 1'b0; ce_b = 1'b0;
        repeat (wc + 3) @(negedge clk);
    endtask

    initial begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 1024; i++) begin
                mdl_ok[u][i]  = 1'b0;
                mdl_mem[u][i] = 32'h0;
            end
        rst = 1'b1; ce_a = 1'b1; ce_b = 1'b1; we = 1'b1; sel = 4'hF;
        addr = 32'h10; wdata = 32'hFFFF_FFFF;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst ack",  {31'd0, ack_a},  32'd0);
            check_val("rst data", data_a,          32'd0);
            check_val("rst err",  {31'd0, err_a},  32'd0);
            check_val("rst busy", {31'd0, busy_a}, 32'd0);
            check_val("rst busy b", {31'd0, busy_b}, 32'd0);
        end
        rst = 1'b0; ce_a = 1'b0; ce_b = 1'b0;
        @(negedge clk);
        check_val("idle busy", {31'd0, busy_a}, 32'd0);

        for (int u = 0; u < 2; u++) begin
            do_req(u, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
            do_req(u, 1'b0, 4'h0, 32'h10, 32'h0);
            do_req(u, 1'b1, 4'h2, 32'h10, 32'h0000_AA00);
            do_req(u, 1'b0, 4'hF, 32'h10, 32'h0);
            do_req(u, 1'b1, 4'h0, 32'h10, 32'h5555_5555);
            do_req(u, 1'b0, 4'hF, 32'h10, 32'h0);
            do_req(u, 1'b1, 4'hF, 32'h1000, 32'h1111_1111);
            do_req(u, 1'b0, 4'hF, 32'h1000, 32'h0);
            do_req(u, 1'b1, 4'hF, 32'hFFC, 32'hCAFE_F00D);
            do_req(u, 1'b0, 4'hF, 32'hFFC, 32'h0);
        end
        check_val("t3 model word", mdl_mem[0][4], 32'hDEAD_AAEF);

        // store aborted by reset while waiting
        do_req(0, 1'b1, 4'hF, 32'h20, 32'h0BAD_F00D);
        @(negedge clk);
        we = 1'b1; sel = 4'hF; addr = 32'h20; wdata = 32'h1234_5678; ce_a = 1'b1;
        @(negedge clk);
        ce_a = 1'b0;
        check_val("abort busy before", {31'd0, busy_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort busy", {31'd0, busy_a}, 32'd0);
        check_val("abort ack",  {31'd0, ack_a},  32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("abort no ack", {31'd0, ack_a}, 32'd0);
        end
        do_req(0, 1'b0, 4'hF, 32'h20, 32'h0);

        hold_test(0);
        hold_test(1);

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 60; i++) begin
                int r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                if (r < 7)       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                else if (r == 7) a = 32'hFFC;
                else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 100)) * 4;
                else             a = $urandom;
                do_req(u, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
